// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU: opcodes, FSM states,
// instruction field positions and flag bit indices.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_XOR = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7,
    OP_LDI = 4'h8,
    OP_LD  = 4'h9,
    OP_ST  = 4'hA,
    OP_JMP = 4'hB,
    OP_BZ  = 4'hC,
    OP_OUT = 4'hD,
    OP_HLT = 4'hE,
    OP_RSV = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam int OP_MSB  = 9;
  localparam int OP_LSB  = 6;
  localparam int RA_MSB  = 5;
  localparam int RA_LSB  = 3;
  localparam int RB_MSB  = 2;
  localparam int RB_LSB  = 0;
  localparam int TGT_MSB = 5;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

endpackage

// File: rtl/cpu_regfile.sv
// Eight-entry register file: two combinational read ports, one synchronous
// write port, all entries cleared by the asynchronous reset.
module cpu_regfile #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [2:0]        rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] regs_d [8];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_en && (wr_addr == 3'(i))) begin
        regs_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd_a_data = regs_q[rd_a_addr];
  assign rd_b_data = regs_q[rd_b_addr];

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle 10-bit-instruction CPU with handshaked instruction/data memories.
// All bus outputs come from registers or the current state, never from an ack.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 8,
  parameter int DMEM_AW = 6
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [9:0]         imem_data,
  input  logic               imem_ack,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  input  logic               dmem_ack,
  output logic [DATA_W-1:0]  out_port,
  output logic               halted,
  output logic [2:0]         flags,
  output logic [PC_W-1:0]    dbg_pc,
  output logic [2:0]         dbg_state
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [9:0]        ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [2:0]        flags_q, flags_d;
  logic [DATA_W-1:0] out_q, out_d;

  logic              rf_we;
  logic [DATA_W-1:0] rf_a, rf_b;
  logic [DATA_W:0]   alu_wide;
  opcode_e           op;
  logic [PC_W-1:0]   target;

  assign op     = opcode_e'(ir_q[OP_MSB:OP_LSB]);
  assign target = PC_W'(ir_q[TGT_MSB:0]);

  cpu_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .rd_a_addr (ir_q[RA_MSB:RA_LSB]),
    .rd_a_data (rf_a),
    .rd_b_addr (ir_q[RB_MSB:RB_LSB]),
    .rd_b_data (rf_b),
    .wr_en     (rf_we),
    .wr_addr   (ir_q[RA_MSB:RA_LSB]),
    .wr_data   (res_q)
  );

  // Bit DATA_W of alu_wide carries the C flag for every ALU op.
  always_comb begin
    alu_wide = '0;
    case (op)
      OP_ADD:  alu_wide = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  alu_wide = {1'b0, a_q} - {1'b0, b_q};
      OP_AND:  alu_wide = {1'b0, a_q & b_q};
      OP_OR:   alu_wide = {1'b0, a_q | b_q};
      OP_XOR:  alu_wide = {1'b0, a_q ^ b_q};
      OP_SHL:  alu_wide = {a_q, 1'b0};
      OP_SHR:  alu_wide = {a_q[0], 1'b0, a_q[DATA_W-1:1]};
      default: alu_wide = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    flags_d = flags_q;
    out_d   = out_q;
    rf_we   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_a;
        b_d     = rf_b;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
            res_d           = alu_wide[DATA_W-1:0];
            flags_d[FLAG_Z] = (alu_wide[DATA_W-1:0] == '0);
            flags_d[FLAG_C] = alu_wide[DATA_W];
            flags_d[FLAG_N] = alu_wide[DATA_W-1];
            state_d         = S_WB;
          end
          OP_LDI: begin
            res_d   = DATA_W'(ir_q[RB_MSB:RB_LSB]);
            state_d = S_WB;
          end
          OP_LD, OP_ST: state_d = S_MEM;
          OP_JMP:       pc_d = target;
          OP_BZ: begin
            if (flags_q[FLAG_Z]) begin
              pc_d = target;
            end
          end
          OP_OUT:  out_d   = a_q;
          OP_HLT:  state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (op == OP_ST) begin
            state_d = S_FETCH;
          end else begin
            res_d   = dmem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flags_q <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      out_q   <= out_d;
    end
  end

  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign dmem_req   = (state_q == S_MEM);
  assign dmem_we    = (op == OP_ST);
  assign dmem_addr  = b_q[DMEM_AW-1:0];
  assign dmem_wdata = a_q;
  assign out_port   = out_q;
  assign halted     = (state_q == S_HALT);
  assign flags      = flags_q;
  assign dbg_pc     = pc_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/multicycle_cpu.md
Name: multicycle_cpu

Overview:
- Parametrised multi-cycle successor to the single-cycle CPU top.
- Executes one 10-bit instruction over 3–5 cycles via a control FSM.
- Instruction and data memories are external and reached through req/ack handshakes, so wait-state memories are supported.
- Adds halt, register-indirect load/store, conditional branch on Z, and a latched output port that drives the 7-segment display decoder.

Parameters:
- DATA_W, 8, datapath, register and data-memory word width (>=4).
- PC_W, 8, program counter / instruction address width (>=6).
- DMEM_AW, 6, data-memory address width (<=DATA_W).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address (= PC).
- imem_data  in  10  instruction word, valid when imem_ack=1.
- imem_ack  in  1  fetch complete.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1=store, 0=load.
- dmem_addr  out  DMEM_AW  data address.
- dmem_wdata  out  DATA_W  store data.
- dmem_rdata  in  DATA_W  load data, valid when dmem_ack=1.
- dmem_ack  in  1  data access complete.
- out_port  out  DATA_W  value written by OUT.
- halted  out  1  core is in HALT.
- flags  out  3  {N,C,Z}.
- dbg_pc  out  PC_W  current PC.
- dbg_state  out  3  FSM state encoding.

Behaviour:
- Instruction format: [9:6] op, [5:3] ra, [2:0] rb. JMP and BZ take target [5:0], zero-extended to PC_W.
- Opcodes:
  - 0 NOP
  - 1 ADD ra+=rb
  - 2 SUB ra-=rb
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SHL ra<<=1
  - 7 SHR ra>>=1 (logical)
  - 8 LDI ra=rb field, zero-extended
  - 9 LD ra=M[R[rb][DMEM_AW-1:0]]
  - A ST M[R[rb][DMEM_AW-1:0]]=R[ra]
  - B JMP
  - C BZ (branch if Z=1)
  - D OUT out_port=R[ra]
  - E HLT
  - F reserved, executes as NOP.
- Register file: 8 x DATA_W, all zero on reset.
- FSM states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH:
  - imem_req=1; imem_addr=PC.
  - On a clock edge with imem_ack=1: IR<=imem_data, PC<=PC+1 (wraps mod 2^PC_W), go to DECODE.
  - imem_ack sampled 0: stay, with req and addr held stable.
- DECODE: latch A=R[ra], B=R[rb]; go to EXEC.
- EXEC:
  - ALU ops 1–7: compute result, update flags → WB.
  - LDI → WB.
  - LD/ST → MEM.
  - JMP: PC<=target → FETCH.
  - BZ: PC<=target if Z, else PC unchanged → FETCH.
  - OUT: out_port<=A → FETCH.
  - NOP/F → FETCH.
  - HLT → HALT.
- MEM:
  - dmem_req=1, dmem_we=(op==ST), dmem_addr=B[DMEM_AW-1:0], dmem_wdata=A.
  - Held stable until dmem_ack=1.
  - On ack: ST → FETCH; LD captures dmem_rdata → WB.
- WB: R[ra]<=result/immediate/load data → FETCH.
- Latency with zero-wait memories (ack high in the request cycle):
  - ALU/LDI 4 cycles; LD 5; ST 4; JMP/BZ/OUT/NOP 3.
  - Each sampled-low ack adds one cycle.
- Flag rules: only ops 1–7 update flags. Z=(result==0), N=result[DATA_W-1].
  - ADD: C=carry out.
  - SUB: C=borrow (A<B unsigned).
  - SHL: C=A[DATA_W-1].
  - SHR: C=A[0].
  - Logic ops: C=0.
  - Result is truncated to DATA_W.
- HALT: halted=1, no requests issued; exits only via reset.
- An ack arriving while the corresponding req=0 is ignored.
- Reset values (asynchronous, any state, including mid-handshake): state=FETCH, PC=0, IR=0, flags=0, regs=0, out_port=0, halted=0.
  - Because state resets to FETCH, imem_req=1 during and after reset; dmem_req drops to 0 immediately.
  - The first fetch after release is address 0.
- Outputs are registered or decoded from state only; no combinational path from ack to req.

Decomposition:
- cpu_pkg holds:
  - opcode constants OP_NOP..OP_HLT
  - FSM state encodings
  - instruction field positions (OP_MSB=9, RA_LSB=3, RB_LSB=0)
  - flag bit indices (Z=0, C=1, N=2).
- Sub-module cpu_regfile(DATA_W): 8 entries, two combinational reads, one synchronous write, async reset.
- ALU and FSM stay inline.

Test Plan:
- Program LDI r1,5; LDI r2,3; ADD r1,r2; OUT r1; HLT with zero-wait memories → out_port=8, flags=000, halted=1 after 4+4+4+3+3=18 cycles.
- DATA_W=8: LDI r1,7; SHL r1 ×5 → r1=0xE0, C=0. One more SHL → r1=0xC0, C=1, N=1, Z=0. SUB r1,r1 → Z=1, C=0.
- Memory round-trip (LDI r3,6; LDI r4,2; ST r3,[r4]; LD r5,[r4]; OUT r5) with dmem_ack delayed 3 cycles:
  - dmem_req/addr=2/wdata=6 held stable for 4 cycles.
  - out_port=6.
  - LD takes 8 cycles.
- Branches: BZ with Z=0 falls through to PC+1. BZ with Z=1 to target 0x3F executes the instruction at 0x3F. PC=2^PC_W-1 fetch wraps PC to 0.
- Assert reset while in MEM with dmem_req=1 → dmem_req=0, dbg_state=0, dbg_pc=0, out_port=0 in the same cycle. After release, the first imem_addr is 0.
- Toggle imem_ack while in HALT or in DECODE → no state change and no PC change.
